// File: rtl/ro_trng_core_if.sv
// Readout bus of ro_trng_core. It carries one WORD_W-bit entropy word per
// handshake from the core (master) to the consumer (slave).
interface ro_trng_core_if #(
    parameter int WORD_W = 8
);
    // A word transfers on a clock edge where rd_valid & rd_ready are both high.
    // While rd_valid is high and rd_ready is low, rd_valid and rd_data hold
    // their values. rd_valid never waits on rd_ready.
    logic              rd_valid;
    logic              rd_ready;
    logic [WORD_W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/ro_trng_core.sv
// Ring-oscillator entropy core: gated rings, 2-flop synchronisers, XOR combiner,
// sample timer, word packer and repetition-count health test. Optional: VON_NEUMANN_EN.
module ro_inv_cell (
    input  logic a_i,
    output logic y_o
);
    assign y_o = ~a_i;
endmodule

module ro_trng_core #(
    parameter int N_RINGS   = 4,
    parameter int N_STAGES  = 5,
    parameter int WORD_W    = 8,
    parameter int REP_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [7:0]            div_i,
    input  logic                  tst_en_i,
    input  logic                  tst_bit_i,
    ro_trng_core_if.master        rd,
    output logic                  health_fail_o,
    output logic                  ring_raw_o
);
    localparam int              BC_W    = $clog2(WORD_W + 1);
    localparam logic [7:0]      REP_LIM = 8'(REP_LIMIT);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(WORD_W);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);

    logic [N_RINGS-1:0] tap;
    logic [N_RINGS-1:0] sync1_q, sync2_q;

    for (genvar r = 0; r < N_RINGS; r++) begin : g_ring
        logic fb;
        logic nand_y;
        assign nand_y = ~(en_i & fb);
        for (genvar s = 1; s < N_STAGES; s++) begin : g_stage
            logic y;
            if (s == 1) begin : g_first
                ro_inv_cell u_inv (.a_i(nand_y), .y_o(y));
            end else begin : g_next
                ro_inv_cell u_inv (.a_i(g_stage[s-1].y), .y_o(y));
            end
        end
        assign tap[r] = g_stage[N_STAGES-1].y;
`ifdef SYNTHESIS
        assign fb = tap[r];
`else
        // Zero-delay models close the ring through a flop so evaluation settles.
        logic fb_q;
        always_ff @(posedge clk) begin
            if (rst) fb_q <= 1'b0;
            else     fb_q <= tap[r];
        end
        assign fb = fb_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= tap;
            sync2_q <= sync1_q;
        end
    end
    assign ring_raw_o = ^sync2_q;

    logic              strobe, samp, out_free, bit_acc, bit_val;
    logic [7:0]        cnt_q, cnt_d, rep_q, rep_d;
    logic              prev_q, prev_d, health_q, health_d;
    logic [WORD_W-1:0] sh_q, sh_d, sh_n, data_q, data_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic              valid_q, valid_d;
`ifdef VON_NEUMANN_EN
    logic              pair_have_q, pair_have_d, pair_first_q, pair_first_d;
`endif

    assign strobe = en_i && (cnt_q == div_i);
    assign samp   = tst_en_i ? tst_bit_i : ring_raw_o;

    always_comb begin
        cnt_d    = cnt_q;
        rep_d    = rep_q;
        prev_d   = prev_q;
        health_d = health_q;
        sh_d     = sh_q;
        bc_d     = bc_q;
        valid_d  = valid_q;
        data_d   = data_q;
        bit_acc  = 1'b0;
        bit_val  = samp;
        out_free = !valid_q || rd.rd_ready;
`ifdef VON_NEUMANN_EN
        pair_have_d  = pair_have_q;
        pair_first_d = pair_first_q;
`endif
        if (!en_i || strobe) cnt_d = 8'd0;
        else                 cnt_d = cnt_q + 8'd1;

        // Health test sees the raw sample, ahead of any debiasing.
        if (strobe) begin
            prev_d = samp;
            if (rep_q == 8'd0 || samp != prev_q) rep_d = 8'd1;
            else if (rep_q < REP_LIM)            rep_d = rep_q + 8'd1;
            if (rep_d == REP_LIM) health_d = 1'b1;
`ifdef VON_NEUMANN_EN
            if (!pair_have_q) begin
                pair_have_d  = 1'b1;
                pair_first_d = samp;
            end else begin
                pair_have_d = 1'b0;
                bit_acc     = (pair_first_q != samp);
                bit_val     = pair_first_q;
            end
`else
            bit_acc = 1'b1;
`endif
        end
`ifdef VON_NEUMANN_EN
        if (!en_i) begin
            pair_have_d  = 1'b0;
            pair_first_d = 1'b0;
        end
`endif
        sh_n = {sh_q[WORD_W-2:0], bit_val};

        if (valid_q && rd.rd_ready) valid_d = 1'b0;
        // A full shifter means a completed word is stalled; new bits are dropped.
        if (bc_q == BC_FULL) begin
            if (out_free) begin
                data_d  = sh_q;
                valid_d = 1'b1;
                bc_d    = '0;
            end
        end else if (bit_acc) begin
            sh_d = sh_n;
            if (bc_q == BC_LAST) begin
                if (out_free) begin
                    data_d  = sh_n;
                    valid_d = 1'b1;
                    bc_d    = '0;
                end else begin
                    bc_d = BC_FULL;
                end
            end else begin
                bc_d = bc_q + 1'b1;
            end
        end
        if (!en_i) bc_d = '0;
        if (health_d) begin
            valid_d = 1'b0;
            data_d  = '0;
            sh_d    = '0;
            bc_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            rep_q    <= '0;
            prev_q   <= 1'b0;
            health_q <= 1'b0;
            sh_q     <= '0;
            bc_q     <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rep_q    <= rep_d;
            prev_q   <= prev_d;
            health_q <= health_d;
            sh_q     <= sh_d;
            bc_q     <= bc_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

`ifdef VON_NEUMANN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_have_q  <= 1'b0;
            pair_first_q <= 1'b0;
        end else begin
            pair_have_q  <= pair_have_d;
            pair_first_q <= pair_first_d;
        end
    end
`endif

    assign rd.rd_valid   = valid_q;
    assign rd.rd_data    = data_q;
    assign health_fail_o = health_q;
endmodule

// File: tb/tb_ro_trng_core.sv
// Directed bench for ro_trng_core: reset, packing, timer, stall, health test,
// reset recovery, and the pairing debiaser when VON_NEUMANN_EN is defined.
module tb_ro_trng_core;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst, en, tst_en, tst_bit, health_fail, ring_raw;
    logic [7:0] div;
    int         checks = 0;
    int         failures = 0;
    logic [W-1:0] exp_q[$];

    ro_trng_core_if #(.WORD_W(W)) rd_if ();

    ro_trng_core #(.N_RINGS(4), .N_STAGES(5), .WORD_W(W), .REP_LIMIT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en),
        .div_i         (div),
        .tst_en_i      (tst_en),
        .tst_bit_i     (tst_bit),
        .rd            (rd_if),
        .health_fail_o (health_fail),
        .ring_raw_o    (ring_raw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         tb;
        logic         rdy;
        logic         ev;
        logic [W-1:0] ed;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic b, input logic rdy);
        tst_bit        = b;
        rd_if.rd_ready = rdy;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; tst_en = 1'b1; tst_bit = 1'b0; div = 8'd0;
        rd_if.rd_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic feed_word(input logic [W-1:0] w, input logic rdy, input string name);
        for (int i = 0; i < W; i++) begin
            drive(w[W-1-i], rdy);
            step();
            check({name, "_valid"}, 32'(rd_if.rd_valid), 32'(i == W - 1));
        end
        check({name, "_data"}, 32'(rd_if.rd_data), 32'(w));
    endtask

    initial begin
        vec_t v[12];
        logic [W-1:0] got;

        do_reset();
        check("rst_valid", 32'(rd_if.rd_valid), 32'd0);
        check("rst_data", 32'(rd_if.rd_data), 32'd0);
        check("rst_health", 32'(health_fail), 32'd0);
        check("rst_ring_raw", 32'(ring_raw), 32'd0);

`ifndef VON_NEUMANN_EN
        // Bits 1,0,1,0,0,1,1,0 -> 0xA6 after 8 edges, held while rd_ready=0.
        v[0]  = '{1'b1, 1'b0, 1'b0, 8'h00};
        v[1]  = '{1'b0, 1'b0, 1'b0, 8'h00};
        v[2]  = '{1'b1, 1'b0, 1'b0, 8'h00};
        v[3]  = '{1'b0, 1'b0, 1'b0, 8'h00};
        v[4]  = '{1'b0, 1'b0, 1'b0, 8'h00};
        v[5]  = '{1'b1, 1'b0, 1'b0, 8'h00};
        v[6]  = '{1'b1, 1'b0, 1'b0, 8'h00};
        v[7]  = '{1'b0, 1'b0, 1'b1, 8'hA6};
        v[8]  = '{1'b1, 1'b0, 1'b1, 8'hA6};
        v[9]  = '{1'b0, 1'b0, 1'b1, 8'hA6};
        v[10] = '{1'b1, 1'b0, 1'b1, 8'hA6};
        v[11] = '{1'b1, 1'b0, 1'b1, 8'hA6};
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(v[i].tb, v[i].rdy);
            step();
            check("t1_valid", 32'(rd_if.rd_valid), 32'(v[i].ev));
            check("t1_data", 32'(rd_if.rd_data), 32'(v[i].ed));
        end

        // div=3: strobe every 4th edge, a word every 32 edges.
        do_reset();
        div = 8'd3; en = 1'b1;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hAA);
        for (int e = 1; e <= 64; e++) begin
            drive(((e - 1) / 4) % 2 == 0, 1'b1);
            step();
            check("t2_valid", 32'(rd_if.rd_valid), 32'(e % 32 == 0));
            if (rd_if.rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("t2_extra_word", 32'(rd_if.rd_data), 32'hFFFF_FFFF);
                end else begin
                    got = exp_q.pop_front();
                    check("t2_data", 32'(rd_if.rd_data), 32'(got));
                end
            end
        end
        check("t2_words_left", 32'(exp_q.size()), 32'd0);

        // Stall: second word waits in the shifter, later bits dropped.
        do_reset();
        en = 1'b1;
        feed_word(8'h3C, 1'b0, "t3_first");
        for (int i = 0; i < W; i++) begin
            drive(8'h5A >> (W - 1 - i), 1'b0);
            step();
        end
        check("t3_hold_valid", 32'(rd_if.rd_valid), 32'd1);
        check("t3_hold_data", 32'(rd_if.rd_data), 32'h3C);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0);
            step();
        end
        check("t3_drop_data", 32'(rd_if.rd_data), 32'h3C);
        drive(1'b1, 1'b1);
        step();
        check("t3_swap_valid", 32'(rd_if.rd_valid), 32'd1);
        check("t3_swap_data", 32'(rd_if.rd_data), 32'h5A);
        step();
        check("t3_drain_valid", 32'(rd_if.rd_valid), 32'd0);

        // Health: constant 1 trips at the 16th strobe after one 0xFF word.
        do_reset();
        en = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            drive(1'b1, e >= 9);
            step();
            check("t4_valid", 32'(rd_if.rd_valid), 32'(e == 8));
            check("t4_health", 32'(health_fail), 32'(e == 16));
            if (e == 8) check("t4_word", 32'(rd_if.rd_data), 32'hFF);
        end
        check("t4_data_clr", 32'(rd_if.rd_data), 32'd0);
        for (int e = 0; e < 12; e++) begin
            drive(e[0], 1'b0);
            step();
            check("t4_dead_valid", 32'(rd_if.rd_valid), 32'd0);
            check("t4_sticky", 32'(health_fail), 32'd1);
        end
        do_reset();
        check("t4_rst_health", 32'(health_fail), 32'd0);

        // Reset mid-word, then reset with a pending word.
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_mid_valid", 32'(rd_if.rd_valid), 32'd0);
        feed_word(8'h81, 1'b0, "t5_post");
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_pend_valid", 32'(rd_if.rd_valid), 32'd0);
        check("t5_pend_data", 32'(rd_if.rd_data), 32'd0);
        check("t5_pend_health", 32'(health_fail), 32'd0);
        feed_word(8'hC3, 1'b0, "t5_after");
`else
        // Pairs (0,1),(1,0),(1,1),(1,0) -> bits 0,1,1; 8 bits after 20 samples = 0x6D.
        en = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            logic [7:0] pat;
            pat = 8'b0110_1110;
            drive(pat[7 - ((e - 1) % 8)], 1'b0);
            step();
            check("vn_valid", 32'(rd_if.rd_valid), 32'(e == 20));
        end
        check("vn_data", 32'(rd_if.rd_data), 32'h6D);

        // Half pair discarded by en toggle: (1,0) x8 then gives 0xFF.
        do_reset();
        en = 1'b1;
        drive(1'b1, 1'b0);
        step();
        en = 1'b0;
        step();
        en = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            drive(e % 2 == 1, 1'b0);
            step();
            check("vn_en_valid", 32'(rd_if.rd_valid), 32'(e == 16));
        end
        check("vn_en_data", 32'(rd_if.rd_data), 32'hFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ro_trng_core.md
Name: ro_trng_core

Overview:
Parametrised ring-oscillator entropy core and the next generation of the single-inverter ring stage. It builds N_RINGS gated rings of N_STAGES inverting stages each, then synchronises and XOR-combines their outputs. A programmable sample timer captures the combined bit, the core packs samples into WORD_W-bit words behind a valid/ready handshake, and a repetition-count health test watches the raw samples. It sits between the analog-ish ring array and the TRNG readout/controller logic.

Parameters:
N_RINGS, 4, number of independent rings (>=1)
N_STAGES, 5, inverting stages per ring (odd, >=3)
WORD_W, 8, output word width (>=2)
REP_LIMIT, 16, run length of identical raw samples that trips the health test (2..255)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en  input  1  ring enable and core enable
div  input  8  sample interval: one strobe every div+1 cycles
tst_en  input  1  bypass rings and use tst_bit as the raw sample
tst_bit  input  1  deterministic test sample, used without synchronisation
rd_valid  output  1  output word available
rd_ready  input  1  consumer accepts word
rd_data  output  WORD_W  output word; first-captured bit is the MSB
health_fail  output  1  sticky repetition-count failure
ring_raw  output  1  synchronised XOR of all rings (debug)

Behaviour:
- Rings: stage 0 of each ring is a NAND of en with the ring feedback; the remaining stages are hierarchy-preserved inverter cells. Rings are stopped when en=0.
- Ring taps: each ring tap passes through a 2-flop synchroniser. The synchronised taps are XORed to form ring_raw.
- Raw sample: s = tst_en ? tst_bit : ring_raw.
- Reset: cnt=0, shifter=0, bitcnt=0, rd_valid=0, rd_data=0, health_fail=0, run counter=0, synchroniser flops=0. Reset mid-operation discards any partial word and any pending output word.
- Sample timer: 8-bit cnt, active while en=1. When cnt==div, a strobe fires and cnt goes to 0; otherwise cnt increments. div=0 gives a strobe every cycle.
- en=0: cnt, bitcnt and the pairing state clear on the next edge. The output register and health_fail are retained.
- Packing: each accepted bit b shifts into the LSB of the shifter and bitcnt increments.
- Word completion: on the edge that captures the WORD_W-th bit, if the output register is free (rd_valid=0, or rd_valid&rd_ready on that edge), the completed word loads into rd_data, rd_valid=1 and bitcnt=0.
- Stall: if the output register is busy, the shifter holds the full word and further bits are dropped. On the first edge where the output register frees, that word loads.
- Handshake: transfer occurs on an edge with rd_valid&rd_ready.
  - rd_data and rd_valid stay stable while rd_valid&!rd_ready.
  - Transfer and a new load on the same edge are allowed; rd_valid stays 1 with the new data.
- Latency: with tst_en=1, div=0 and the debias feature off, rd_valid rises after exactly WORD_W edges.
- Health test: runs on every strobe using the raw sample s, before any debiasing.
  - A run counter saturates at REP_LIMIT. It is set to 1 when s differs from the previous sample, and increments when s equals it.
  - On the edge where the run reaches REP_LIMIT, health_fail is set. It clears only on rst.
- While health_fail=1: rd_valid is forced to 0, the output register and shifter clear, and no words are produced.

Optional Feature:
VON_NEUMANN_EN:
- Defined: strobed samples are paired. Pair (0,1) yields bit 0, (1,0) yields bit 1, and (0,0)/(1,1) yield nothing. The pairing state clears on en=0 and on rst. Word latency becomes at least 2*WORD_W strobes.
- Undefined: every strobed sample is an accepted bit. No pairing logic is built.

Test Plan:
- rst, then en=1, tst_en=1, div=0, tst_bit sequence 1,0,1,0,0,1,1,0, rd_ready=0 -> rd_valid=1 after 8 edges, rd_data=0xA6, held stable while rd_ready=0.
- div=3, alternating tst_bit, rd_ready=1 -> strobes every 4 cycles; rd_valid pulses once per 32 cycles with data 0xAA (first sample 1).
- rd_ready=0 while two more words complete -> the second word waits in the shifter and later bits are dropped. Raise rd_ready -> the first word transfers and the second loads the same edge with rd_valid continuous.
- tst_bit held at 1, div=0, REP_LIMIT=16 -> one word 0xFF delivered. health_fail=1 at the 16th strobe, rd_valid=0 afterwards, and it persists until rst.
- VON_NEUMANN_EN: pairs (0,1),(1,0),(1,1),(1,0) repeated -> accepted bits 0,1,1; the 8-bit word forms from accepted bits only. Toggling en mid-pair discards the half pair.
- Assert rst mid-word and with rd_valid=1 -> all outputs 0 next edge; the first word afterwards comes only from post-reset samples.
